// File: rtl/password_programmer.sv
`default_nettype none
// ============================================================================
//  Module      : password_programmer
//  Description : Writer side of a 4-digit hex password lock. Captures a code
//                one digit per load edge, asks for it again, and commits it to
//                code_out on a match. Progress and status are shown on four
//                active-low 7-segment displays ({g,f,e,d,c,b,a}).
//                Optional macro PROG_MASK_EN: taken digits show as dashes.
//  Revision    : 1.0  initial release
// ============================================================================
module password_programmer #(
  parameter logic [15:0] DEFAULT_CODE = 16'h1234,
  parameter int          ERR_HOLD     = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [3:0]  SW,
  output logic [15:0] code_out,
  output logic        code_wr,
  output logic        busy,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0
);

  localparam int             c_CNT_W     = $clog2(ERR_HOLD + 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(ERR_HOLD - 1);
  localparam logic [6:0]     c_SEG_BLANK = 7'b1111111;
  localparam logic [6:0]     c_SEG_DASH  = 7'b0111111;
  localparam logic [27:0]    c_DISP_DONE = {7'b0100001, 7'b0100011, 7'b0101011, 7'b0000110};
  localparam logic [27:0]    c_DISP_ERR  = {7'b0000110, 7'b0101111, 7'b0101111, 7'b1111111};

  typedef enum logic [1:0] {
    S_ENTER   = 2'd0,
    S_CONFIRM = 2'd1,
    S_DONE    = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t               r_state;
  logic [1:0]           r_idx;
  logic [15:0]          r_new;
  logic [15:0]          r_cmp;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_load_q;
  logic [27:0]          r_hex;

  logic                 w_ld_edge;
  logic [15:0]          w_new_upd;
  logic [15:0]          w_cmp_upd;
  logic [2:0]           w_taken;

  // Standard hex digit to active-low segment pattern.
  function automatic logic [6:0] f_hex(input logic [3:0] d);
    case (d)
      4'h0: f_hex = 7'b1000000;
      4'h1: f_hex = 7'b1111001;
      4'h2: f_hex = 7'b0100100;
      4'h3: f_hex = 7'b0110000;
      4'h4: f_hex = 7'b0011001;
      4'h5: f_hex = 7'b0010010;
      4'h6: f_hex = 7'b0000010;
      4'h7: f_hex = 7'b1111000;
      4'h8: f_hex = 7'b0000000;
      4'h9: f_hex = 7'b0010000;
      4'hA: f_hex = 7'b0001000;
      4'hB: f_hex = 7'b0000011;
      4'hC: f_hex = 7'b1000110;
      4'hD: f_hex = 7'b0100001;
      4'hE: f_hex = 7'b0000110;
      default: f_hex = 7'b0001110;
    endcase
  endfunction

  // Left-aligned view of the first n digits of a buffer; the rest blank.
  function automatic logic [27:0] f_digits(input logic [15:0] b, input logic [2:0] n);
    logic [6:0] seg;
    f_digits = {4{c_SEG_BLANK}};
    for (int i = 0; i < 4; i++) begin
`ifdef PROG_MASK_EN
      seg = c_SEG_DASH;
`else
      seg = f_hex(b[15-4*i -: 4]);
`endif
      if (3'(i) < n) f_digits[27-7*i -: 7] = seg;
    end
  endfunction

  assign w_ld_edge = load & ~r_load_q;
  assign w_taken   = {1'b0, r_idx} + 3'd1;

  // Buffers with the current SW dropped into the slot selected by idx.
  always_comb begin
    w_new_upd = r_new;
    w_cmp_upd = r_cmp;
    case (r_idx)
      2'd0: begin w_new_upd[15:12] = SW; w_cmp_upd[15:12] = SW; end
      2'd1: begin w_new_upd[11:8]  = SW; w_cmp_upd[11:8]  = SW; end
      2'd2: begin w_new_upd[7:4]   = SW; w_cmp_upd[7:4]   = SW; end
      default: begin w_new_upd[3:0] = SW; w_cmp_upd[3:0] = SW; end
    endcase
  end

  // Entry/confirm state machine with registered status and display outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_ENTER;
      r_idx    <= 2'd0;
      r_new    <= 16'h0000;
      r_cmp    <= 16'h0000;
      r_cnt    <= '0;
      r_load_q <= 1'b0;
      r_hex    <= {4{c_SEG_BLANK}};
      code_out <= DEFAULT_CODE;
      code_wr  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      r_load_q <= load;
      code_wr  <= 1'b0;
      case (r_state)
        S_ENTER: begin
          if (w_ld_edge) begin
            r_new <= w_new_upd;
            busy  <= 1'b1;
            if (r_idx == 2'd3) begin
              r_state <= S_CONFIRM;
              r_idx   <= 2'd0;
              r_cmp   <= 16'h0000;
              r_hex   <= {4{c_SEG_DASH}};
            end else begin
              r_idx <= r_idx + 2'd1;
              r_hex <= f_digits(w_new_upd, w_taken);
            end
          end
        end
        S_CONFIRM: begin
          if (w_ld_edge) begin
            r_cmp <= w_cmp_upd;
            if (r_idx == 2'd3) begin
              r_idx <= 2'd0;
              busy  <= 1'b0;
              if (w_cmp_upd == r_new) begin
                r_state  <= S_DONE;
                code_out <= r_new;
                code_wr  <= 1'b1;
                r_hex    <= c_DISP_DONE;
              end else begin
                r_state <= S_ERROR;
                r_cnt   <= '0;
                r_hex   <= c_DISP_ERR;
              end
            end else begin
              r_idx <= r_idx + 2'd1;
              r_hex <= f_digits(w_cmp_upd, w_taken);
            end
          end
        end
        S_DONE: begin
          // A fresh edge here starts a new entry with SW as its first digit.
          if (w_ld_edge) begin
            r_state <= S_ENTER;
            r_idx   <= 2'd1;
            r_new   <= {SW, 12'h000};
            r_cmp   <= 16'h0000;
            busy    <= 1'b1;
            r_hex   <= f_digits({SW, 12'h000}, 3'd1);
          end
        end
        default: begin
          // ERROR: edges are ignored, including one landing on the timeout cycle.
          if (r_cnt == c_HOLD_LAST) begin
            r_state <= S_ENTER;
            r_idx   <= 2'd0;
            r_new   <= 16'h0000;
            r_cmp   <= 16'h0000;
            busy    <= 1'b0;
            r_hex   <= {4{c_SEG_BLANK}};
          end else if (r_cnt != {c_CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign HEX3 = r_hex[27:21];
  assign HEX2 = r_hex[20:14];
  assign HEX1 = r_hex[13:7];
  assign HEX0 = r_hex[6:0];

endmodule
`default_nettype wire

// File: tb/tb_password_programmer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_password_programmer
//  Description : Directed self-checking bench for password_programmer
//                (ERR_HOLD = 4). Honours PROG_MASK_EN for display expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_password_programmer;

  localparam logic [6:0]  BL   = 7'b1111111;
  localparam logic [6:0]  DS   = 7'b0111111;
  localparam logic [27:0] BLANK4 = {BL, BL, BL, BL};
  localparam logic [27:0] DASH4  = {DS, DS, DS, DS};
  localparam logic [27:0] DONE4  = {7'b0100001, 7'b0100011, 7'b0101011, 7'b0000110};
  localparam logic [27:0] ERR4   = {7'b0000110, 7'b0101111, 7'b0101111, BL};

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        load = 1'b0;
  logic [3:0]  SW   = 4'h0;
  logic [15:0] code_out;
  logic        code_wr;
  logic        busy;
  logic [6:0]  HEX3, HEX2, HEX1, HEX0;
  logic [27:0] hex;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  password_programmer #(.DEFAULT_CODE(16'h1234), .ERR_HOLD(4)) dut (
    .clk(clk), .rst(rst), .load(load), .SW(SW),
    .code_out(code_out), .code_wr(code_wr), .busy(busy),
    .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
  );

  assign hex = {HEX3, HEX2, HEX1, HEX0};

  always #5 clk = ~clk;

  // Count commit pulses just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (code_wr === 1'b1) wr_cnt++;
  end

  // Bench-side hex segment table, active low {g..a}.
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'b1000000; 4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100; 4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001; 4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010; 4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000; 4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000; 4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110; 4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110; default: seg = 7'b0001110;
    endcase
  endfunction

  // Expected display for a digit taken during entry.
  function automatic logic [6:0] tseg(input logic [3:0] d);
`ifdef PROG_MASK_EN
    tseg = (d === 4'hx) ? BL : DS;
`else
    tseg = seg(d);
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b0; load = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge clk); SW = d; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (code_out !== 16'h1234) begin errors++; $display("FAIL reset_code: got %h expected %h", code_out, 16'h1234); end
    checks++; if (code_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", code_wr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (hex !== BLANK4) begin errors++; $display("FAIL reset_hex: got %h expected %h", hex, BLANK4); end
  endtask

  task automatic test_commit();
    wr_cnt = 0;
    press(4'h5);
    checks++; if (hex !== {tseg(4'h5), BL, BL, BL}) begin errors++; $display("FAIL enter1_hex: got %h expected %h", hex, {tseg(4'h5), BL, BL, BL}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL enter1_busy: got %b expected 1", busy); end
    press(4'h6); press(4'h7); press(4'h8);
    checks++; if (hex !== DASH4) begin errors++; $display("FAIL confirm_prompt: got %h expected %h", hex, DASH4); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL confirm_busy: got %b expected 1", busy); end
    press(4'h5); press(4'h6); press(4'h7);
    checks++; if (code_out !== 16'h1234) begin errors++; $display("FAIL precommit_code: got %h expected %h", code_out, 16'h1234); end
    // Last digit: the commit must be visible one cycle after the edge.
    @(negedge clk); SW = 4'h8; load = 1'b1;
    @(negedge clk);
    checks++; if (code_wr !== 1'b1) begin errors++; $display("FAIL commit_wr: got %b expected 1", code_wr); end
    checks++; if (code_out !== 16'h5678) begin errors++; $display("FAIL commit_code: got %h expected %h", code_out, 16'h5678); end
    load = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL commit_pulses: got %0d expected 1", wr_cnt); end
    checks++; if (hex !== DONE4) begin errors++; $display("FAIL done_hex: got %h expected %h", hex, DONE4); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mismatch();
    wr_cnt = 0;
    press(4'h1);
    checks++; if (hex !== {tseg(4'h1), BL, BL, BL}) begin errors++; $display("FAIL done_restart_hex: got %h expected %h", hex, {tseg(4'h1), BL, BL, BL}); end
    press(4'h2); press(4'h3); press(4'h4);
    press(4'h1); press(4'h2); press(4'h3);
    checks++; if (hex !== {tseg(4'h1), tseg(4'h2), tseg(4'h3), BL}) begin errors++; $display("FAIL confirm3_hex: got %h expected %h", hex, {tseg(4'h1), tseg(4'h2), tseg(4'h3), BL}); end
    press(4'h9);
    checks++; if (hex !== ERR4) begin errors++; $display("FAIL err_hex: got %h expected %h", hex, ERR4); end
    checks++; if (code_out !== 16'h5678) begin errors++; $display("FAIL err_code: got %h expected %h", code_out, 16'h5678); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy: got %b expected 0", busy); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL err_pulses: got %0d expected 0", wr_cnt); end
    repeat (2) @(negedge clk);
    checks++; if (hex !== ERR4) begin errors++; $display("FAIL err_held: got %h expected %h", hex, ERR4); end
    @(negedge clk);
    checks++; if (hex !== BLANK4) begin errors++; $display("FAIL err_timeout_hex: got %h expected %h", hex, BLANK4); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_timeout_busy: got %b expected 0", busy); end
    press(4'h7);
    checks++; if (hex !== {tseg(4'h7), BL, BL, BL}) begin errors++; $display("FAIL after_err_hex: got %h expected %h", hex, {tseg(4'h7), BL, BL, BL}); end
  endtask

  task automatic test_reset_midentry();
    press(4'h8);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    do_reset();
    checks++; if (code_out !== 16'h1234) begin errors++; $display("FAIL mid_reset_code: got %h expected %h", code_out, 16'h1234); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    checks++; if (hex !== BLANK4) begin errors++; $display("FAIL mid_reset_hex: got %h expected %h", hex, BLANK4); end
    press(4'h9);
    checks++; if (hex !== {tseg(4'h9), BL, BL, BL}) begin errors++; $display("FAIL mid_reset_idx: got %h expected %h", hex, {tseg(4'h9), BL, BL, BL}); end
  endtask

  task automatic test_hold_load();
    do_reset();
    @(negedge clk); SW = 4'h3; load = 1'b1;
    repeat (10) @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    checks++; if (hex !== {tseg(4'h3), BL, BL, BL}) begin errors++; $display("FAIL hold_hex: got %h expected %h", hex, {tseg(4'h3), BL, BL, BL}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b expected 1", busy); end
    press(4'h4);
    checks++; if (hex !== {tseg(4'h3), tseg(4'h4), BL, BL}) begin errors++; $display("FAIL hold_next_hex: got %h expected %h", hex, {tseg(4'h3), tseg(4'h4), BL, BL}); end
  endtask

  task automatic test_mask();
    do_reset();
    press(4'hA); press(4'hB);
`ifdef PROG_MASK_EN
    checks++; if (hex !== {DS, DS, BL, BL}) begin errors++; $display("FAIL mask_hex: got %h expected %h", hex, {DS, DS, BL, BL}); end
`else
    checks++; if (hex !== {7'b0001000, 7'b0000011, BL, BL}) begin errors++; $display("FAIL ab_hex: got %h expected %h", hex, {7'b0001000, 7'b0000011, BL, BL}); end
`endif
  endtask

  initial begin
    test_reset();
    test_commit();
    test_mismatch();
    test_reset_midentry();
    test_hold_load();
    test_mask();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
